// File: rtl/clk_period_monitor.sv
// ============================================================================
// Module   : clk_period_monitor
// Brief    : Measures period/high time of a slow clock in fast-clock cycles,
//            with lock detection and a sticky no-edge timeout.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             slow_clk,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] C_LOCK     = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] C_RUN_ONE  = RUN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_MEAS = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic             w_rise, w_fall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_pend;
  logic [CNT_W-1:0] w_meas;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_publish;
  logic             w_tmo_hit;

  always_comb begin
    w_rise      = r_s2 & ~r_s3;
    w_fall      = ~r_s2 & r_s3;
    w_meas      = r_cnt + CNT_W'(1);
    w_tmo_hit   = ~w_rise && (r_cnt == C_TMO_LAST);
    w_publish   = w_rise && (r_state == S_MEAS);
    w_state_nxt = r_state;
    w_run_nxt   = r_run;

    // IDLE waits for a fall so the post-reset 0->1 synchroniser artefact is ignored
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_ARM;
      S_ARM:   if (w_rise) w_state_nxt = S_MEAS;
      S_MEAS:  w_state_nxt = S_MEAS;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_publish) begin
      if ((r_run != '0) && (w_meas == period)) begin
        w_run_nxt = (r_run >= C_LOCK) ? C_LOCK : r_run + C_RUN_ONE;
      end else begin
        w_run_nxt = C_RUN_ONE;
      end
    end

    if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
      w_run_nxt   = '0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_cnt        <= '0;
      r_high_pend  <= '0;
      r_run        <= '0;
      r_state      <= S_IDLE;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      r_s1    <= slow_clk;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;

      if (w_rise) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= w_meas;
      end

      if (w_fall && (r_state == S_MEAS)) begin
        r_high_pend <= w_meas;
      end

      period_valid <= w_publish;
      if (w_publish) begin
        period    <= w_meas;
        high_time <= r_high_pend;
        locked    <= (w_run_nxt >= C_LOCK);
      end

      if (w_tmo_hit) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
      end else if (w_rise) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
// ============================================================================
// Module   : tb_clk_period_monitor
// Brief    : Directed self-checking bench for clk_period_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_period_monitor;

  localparam int CNT_W      = 16;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 100;

  logic             in_clk = 1'b0;
  logic             rst    = 1'b1;
  logic             slow_clk = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int p;
    int h;
    int l;
    int c;
  } ent_t;
  ent_t q[$];

  int exp_p2[9] = '{10, 10, 10, 10, 10, 12, 12, 12, 12};
  int exp_l2[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 1};

  clk_period_monitor #(
    .CNT_W(CNT_W),
    .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .in_clk(in_clk),
    .rst(rst),
    .slow_clk(slow_clk),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (period_valid) q.push_back('{int'(period), int'(high_time), int'(locked), cyc});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge in_clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic gen(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      slow_clk = 1'b1;
      repeat (hi) @(negedge in_clk);
      slow_clk = 1'b0;
      repeat (lo) @(negedge in_clk);
    end
  endtask

  initial begin
    // reset state
    @(negedge in_clk);
    do_reset();
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_valid", period_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout", timeout, 0);

    // divide by 4, 2 high / 2 low
    do_reset();
    gen(10, 2, 2);
    repeat (6) @(negedge in_clk);
    check("t1_count", q.size(), 8);
    for (int i = 0; i < q.size(); i++) begin
      check("t1_period", q[i].p, 4);
      check("t1_high", q[i].h, 2);
      check("t1_locked", q[i].l, (i >= 3) ? 1 : 0);
      if (i > 0) check("t1_spacing", q[i].c - q[i-1].c, 4);
    end

    // period 10 -> period 12, lock drop and relock
    do_reset();
    gen(6, 3, 7);
    gen(5, 3, 9);
    repeat (6) @(negedge in_clk);
    check("t2_count", q.size(), 9);
    for (int i = 0; i < q.size() && i < 9; i++) begin
      check("t2_period", q[i].p, exp_p2[i]);
      check("t2_high", q[i].h, 3);
      check("t2_locked", q[i].l, exp_l2[i]);
    end

    // held high from reset -> timeout, then recovery on first rise
    slow_clk = 1'b1;
    do_reset();
    repeat (95) @(negedge in_clk);
    check("t3_tmo_early", timeout, 0);
    repeat (15) @(negedge in_clk);
    check("t3_tmo_set", timeout, 1);
    check("t3_locked", locked, 0);
    check("t3_period", period, 0);
    check("t3_no_valid", q.size(), 0);
    gen(3, 2, 2);
    check("t3_tmo_clear", timeout, 0);

    // stop while locked
    do_reset();
    gen(8, 2, 2);
    check("t4_locked_pre", locked, 1);
    repeat (85) @(negedge in_clk);
    check("t4_tmo_early", timeout, 0);
    check("t4_locked_mid", locked, 1);
    repeat (25) @(negedge in_clk);
    check("t4_tmo_set", timeout, 1);
    check("t4_locked_drop", locked, 0);
    check("t4_period_hold", period, 4);
    check("t4_high_hold", high_time, 2);

    // reset pulse mid-period while locked (period 12, 8 high)
    do_reset();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 12; k++) begin
        slow_clk = (k < 8);
        if (i == 8 && k == 5) begin
          check("t5_locked_pre", locked, 1);
          check("t5_count_pre", q.size(), 7);
          rst = 1'b1;
        end
        @(negedge in_clk);
        if (i == 8 && k == 5) begin
          rst = 1'b0;
          check("t5_rst_period", period, 0);
          check("t5_rst_high", high_time, 0);
          check("t5_rst_valid", period_valid, 0);
          check("t5_rst_locked", locked, 0);
          check("t5_rst_timeout", timeout, 0);
          q.delete();
        end
      end
    end
    repeat (4) @(negedge in_clk);
    check("t5_count_post", q.size(), 2);
    for (int i = 0; i < q.size(); i++) begin
      check("t5_period", q[i].p, 12);
      check("t5_high", q[i].h, 8);
      check("t5_locked", q[i].l, 0);
    end

    // alternating 7/8 periods at an asynchronous phase
    do_reset();
    #($urandom_range(1, 4));
    for (int i = 0; i < 16; i++) begin
      slow_clk = 1'b1;
      #(((i % 2) ? 4 : 3) * 10);
      slow_clk = 1'b0;
      #(((i % 2) ? 4 : 4) * 10);
    end
    @(negedge in_clk);
    repeat (6) @(negedge in_clk);
    check("t6_count", q.size(), 14);
    for (int i = 0; i < q.size(); i++) begin
      check("t6_period_in_set", (q[i].p == 7 || q[i].p == 8) ? 1 : 0, 1);
      check("t6_locked", q[i].l, 0);
    end
    check("t6_locked_end", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
